// File: rtl/udp_tx_arbiter.sv
// Two-channel round-robin arbiter that feeds one UDP sender. It runs one frame at a time and leaves an idle gap after each frame.
// Optional tx_done watchdog, compiled in when UDP_TX_ARB_TIMEOUT_EN is defined.
module udp_tx_arbiter #(
  parameter int unsigned IFG_CYCLES     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ch0_req,
  input  logic [15:0] ch0_byte_num,
  input  logic [31:0] ch0_data,
  input  logic        ch1_req,
  input  logic [15:0] ch1_byte_num,
  input  logic [31:0] ch1_data,
  output logic        ch0_grant,
  output logic        ch1_grant,
  output logic        ch0_rd_en,
  output logic        ch1_rd_en,
  output logic        ch0_done,
  output logic        ch1_done,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [31:0] tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy,
  output logic        cur_ch,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, START, WAIT_DONE, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'(IFG_CYCLES - 1);

  state_t      r_state;
  logic        r_last_ch;
  logic        r_cur_ch;
  logic        r_grant0;
  logic        r_grant1;
  logic        r_done0;
  logic        r_done1;
  logic        r_start_en;
  logic [15:0] r_byte_num;
  logic [7:0]  r_gap_cnt;

  logic        w_v0;
  logic        w_v1;
  logic        w_win;

`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] r_wd_cnt;
  logic        r_timeout_err;
`endif

  // A zero-length request is not a request at all.
  assign w_v0  = ch0_req && (ch0_byte_num != 16'd0);
  assign w_v1  = ch1_req && (ch1_byte_num != 16'd0);
  assign w_win = (w_v0 && w_v1) ? ~r_last_ch : w_v1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last_ch  <= 1'b1;
      r_cur_ch   <= 1'b0;
      r_grant0   <= 1'b0;
      r_grant1   <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_start_en <= 1'b0;
      r_byte_num <= 16'd0;
      r_gap_cnt  <= 8'd0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      r_wd_cnt      <= 16'd0;
      r_timeout_err <= 1'b0;
`endif
    end else begin
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_start_en <= 1'b0;
`ifdef UDP_TX_ARB_TIMEOUT_EN
      r_timeout_err <= 1'b0;
`endif
      case (r_state)
        IDLE: begin
          if (w_v0 || w_v1) begin
            r_state    <= START;
            r_cur_ch   <= w_win;
            r_grant0   <= ~w_win;
            r_grant1   <= w_win;
            r_byte_num <= w_win ? ch1_byte_num : ch0_byte_num;
            r_start_en <= 1'b1;
          end
        end
        START: begin
          r_state <= WAIT_DONE;
`ifdef UDP_TX_ARB_TIMEOUT_EN
          r_wd_cnt <= 16'd0;
`endif
        end
        WAIT_DONE: begin
          // A tx_done landing on the watchdog limit still counts as a normal completion.
          if (tx_done) begin
            r_done0   <= r_grant0;
            r_done1   <= r_grant1;
            r_grant0  <= 1'b0;
            r_grant1  <= 1'b0;
            r_last_ch <= r_cur_ch;
            r_gap_cnt <= 8'd0;
            r_state   <= GAP;
          end
`ifdef UDP_TX_ARB_TIMEOUT_EN
          else if (r_wd_cnt == WD_LAST) begin
            r_timeout_err <= 1'b1;
            r_grant0      <= 1'b0;
            r_grant1      <= 1'b0;
            r_last_ch     <= r_cur_ch;
            r_gap_cnt     <= 8'd0;
            r_state       <= GAP;
          end else begin
            r_wd_cnt <= r_wd_cnt + 16'd1;
          end
`endif
        end
        GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= IDLE;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign ch0_grant   = r_grant0;
  assign ch1_grant   = r_grant1;
  assign ch0_rd_en   = tx_req & r_grant0;
  assign ch1_rd_en   = tx_req & r_grant1;
  assign ch0_done    = r_done0;
  assign ch1_done    = r_done1;
  assign tx_start_en = r_start_en;
  assign tx_byte_num = r_byte_num;
  assign tx_data     = r_grant0 ? ch0_data : (r_grant1 ? ch1_data : 32'd0);
  assign busy        = (r_state != IDLE);
  assign cur_ch      = r_cur_ch;

`ifdef UDP_TX_ARB_TIMEOUT_EN
  assign timeout_err = r_timeout_err;
`else
  // Watchdog compiled out; the parameter stays on the interface.
  assign timeout_err = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Bench for udp_tx_arbiter. A frame-timeline model checks the outputs on every cycle.
// Directed scenarios add literal expectations. Honours UDP_TX_ARB_TIMEOUT_EN.
module tb_udp_tx_arbiter;
  localparam int IFG = 16;
  localparam int TMO = 100;
`ifdef UDP_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ch0_req = 1'b0, ch1_req = 1'b0;
  logic [15:0] ch0_byte_num = 16'd0, ch1_byte_num = 16'd0;
  logic [31:0] ch0_data = 32'd0, ch1_data = 32'd0;
  logic        tx_req = 1'b0, tx_done = 1'b0;
  logic        ch0_grant, ch1_grant, ch0_rd_en, ch1_rd_en, ch0_done, ch1_done;
  logic        tx_start_en, busy, cur_ch, timeout_err;
  logic [15:0] tx_byte_num;
  logic [31:0] tx_data;

  udp_tx_arbiter #(.IFG_CYCLES(IFG), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_req(ch0_req), .ch0_byte_num(ch0_byte_num), .ch0_data(ch0_data),
    .ch1_req(ch1_req), .ch1_byte_num(ch1_byte_num), .ch1_data(ch1_data),
    .ch0_grant(ch0_grant), .ch1_grant(ch1_grant),
    .ch0_rd_en(ch0_rd_en), .ch1_rd_en(ch1_rd_en),
    .ch0_done(ch0_done), .ch1_done(ch1_done),
    .tx_start_en(tx_start_en), .tx_byte_num(tx_byte_num), .tx_data(tx_data),
    .tx_req(tx_req), .tx_done(tx_done),
    .busy(busy), .cur_ch(cur_ch), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-timeline model: a frame is described by the cycle it started and the cycle its gap began.
  bit          m_busy = 0, m_grant = 0, m_cur = 0, m_last = 1, m_inflight = 0;
  bit          m_start = 0, m_done = 0, m_to = 0, m_v0, m_v1;
  logic [15:0] m_byte = 16'd0;
  int          cyc = 0, m_start_cyc = 0, m_end_cyc = 0;

  task automatic end_frame(input string how);
    m_grant    = 1'b0;
    m_last     = m_cur;
    m_inflight = 1'b0;
    m_end_cyc  = cyc;
    $display("frame ch%0d bytes=%0d %s at cycle %0d", m_cur, m_byte, how, cyc);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    m_start = 1'b0; m_done = 1'b0; m_to = 1'b0;
    if (!rst_n) begin
      m_busy = 1'b0; m_grant = 1'b0; m_cur = 1'b0; m_last = 1'b1;
      m_byte = 16'd0; m_inflight = 1'b0;
    end else if (!m_busy) begin
      m_v0 = ch0_req && (ch0_byte_num != 0);
      m_v1 = ch1_req && (ch1_byte_num != 0);
      if (m_v0 || m_v1) begin
        m_cur       = (m_v0 && m_v1) ? !m_last : m_v1;
        m_byte      = m_cur ? ch1_byte_num : ch0_byte_num;
        m_busy      = 1'b1;
        m_grant     = 1'b1;
        m_inflight  = 1'b1;
        m_start     = 1'b1;
        m_start_cyc = cyc;
      end
    end else if (m_inflight) begin
      if (cyc - 1 > m_start_cyc) begin
        if (tx_done) begin
          m_done = 1'b1;
          end_frame("done");
        end else if (TO_EN && (cyc - (m_start_cyc + 1) == TMO)) begin
          m_to = 1'b1;
          end_frame("timeout");
        end
      end
    end else if (cyc == m_end_cyc + IFG) begin
      m_busy = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      check("grant0", 32'(ch0_grant), 32'(m_grant && !m_cur));
      check("grant1", 32'(ch1_grant), 32'(m_grant && m_cur));
      check("done0", 32'(ch0_done), 32'(m_done && !m_cur));
      check("done1", 32'(ch1_done), 32'(m_done && m_cur));
      check("start_en", 32'(tx_start_en), 32'(m_start));
      check("byte_num", 32'(tx_byte_num), 32'(m_byte));
      check("busy", 32'(busy), 32'(m_busy));
      if (m_grant) check("cur_ch", 32'(cur_ch), 32'(m_cur));
      check("tx_data", tx_data, m_grant ? (m_cur ? ch1_data : ch0_data) : 32'd0);
      check("rd_en0", 32'(ch0_rd_en), 32'(tx_req && m_grant && !m_cur));
      check("rd_en1", 32'(ch1_rd_en), 32'(tx_req && m_grant && m_cur));
      check("timeout_err", 32'(timeout_err), 32'(m_to));
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (tx_start_en === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic serve(input int hold, output bit ok, output logic c, output logic [15:0] bn);
    wait_start(ok);
    c  = cur_ch;
    bn = tx_byte_num;
    repeat (hold) @(posedge clk);
    #1 tx_done = 1'b1;
    next_cycle();
    tx_done = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok;
    int k;
    int seen;
    logic c;
    logic [15:0] bn;
    logic [15:0] exp_bn [4];
    exp_bn[0] = 16'd20; exp_bn[1] = 16'd40; exp_bn[2] = 16'd20; exp_bn[3] = 16'd40;

    // Reset state
    next_cycle();
    cmp_en = 1'b1;
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_grants", 32'({ch0_grant, ch1_grant}), 32'd0);
    check("rst_byte_num", 32'(tx_byte_num), 32'd0);
    check("rst_cur_ch", 32'(cur_ch), 32'd0);
    check("rst_tx_data", tx_data, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Single request, tx_done 60 cycles into the frame
    ch0_req = 1'b1; ch0_byte_num = 16'd32; ch0_data = 32'h1111_0000;
    wait_start(ok);
    check("s1_start_seen", 32'(ok), 32'd1);
    check("s1_byte_num", 32'(tx_byte_num), 32'd32);
    check("s1_grant0", 32'(ch0_grant), 32'd1);
    next_cycle();
    ch0_req = 1'b0;
    @(negedge clk);
    check("s1_start_once", 32'(tx_start_en), 32'd0);
    repeat (59) @(posedge clk);
    #1 tx_done = 1'b1;
    @(negedge clk);
    check("s1_done_not_early", 32'(ch0_done), 32'd0);
    next_cycle();
    tx_done = 1'b0;
    k = 1;
    @(negedge clk);
    check("s1_done_pulse", 32'(ch0_done), 32'd1);
    while (busy === 1'b1 && k < 40) begin
      next_cycle();
      k++;
      @(negedge clk);
    end
    check("s1_busy_low_after", 32'(k), 32'd17);

    // Zero-length request, stray tx_done and tx_req in IDLE
    next_cycle();
    ch0_req = 1'b1; ch0_byte_num = 16'd0; tx_done = 1'b1; tx_req = 1'b1;
    next_cycle();
    tx_done = 1'b0;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || tx_start_en || ch0_done || ch1_done || ch0_rd_en || ch1_rd_en) seen++;
    end
    check("zero_len_idle", 32'(seen), 32'd0);
    next_cycle();
    ch0_req = 1'b0; tx_req = 1'b0;

    // ch1 frame: data steering, then reset in WAIT_DONE
    ch1_req = 1'b1; ch1_byte_num = 16'd40;
    wait_start(ok);
    check("s3_start_seen", 32'(ok), 32'd1);
    check("s3_cur_ch", 32'(cur_ch), 32'd1);
    next_cycle();
    tx_req = 1'b1; ch1_data = 32'hA5A5_0001; ch0_data = 32'h0BAD_0BAD;
    @(negedge clk);
    check("steer_tx_data", tx_data, 32'hA5A5_0001);
    check("steer_rd_en1", 32'(ch1_rd_en), 32'd1);
    check("steer_rd_en0", 32'(ch0_rd_en), 32'd0);
    next_cycle();
    tx_req = 1'b0;
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    ch0_req = 1'b1; ch0_byte_num = 16'd20; ch1_req = 1'b1; ch1_byte_num = 16'd40;
    @(negedge clk);
    check("midrst_outputs", 32'({ch0_grant, ch1_grant, ch0_done, ch1_done, tx_start_en, busy, cur_ch, timeout_err}), 32'd0);
    check("midrst_byte_num", 32'(tx_byte_num), 32'd0);
    check("midrst_tx_data", tx_data, 32'd0);

    // Continuous contention alternates ch0, ch1, starting with ch0
    for (int i = 0; i < 4; i++) begin
      serve(3 + i, ok, c, bn);
      check("rr_start_seen", 32'(ok), 32'd1);
      check("rr_cur_ch", 32'(c), 32'(i % 2));
      check("rr_byte_num", 32'(bn), 32'(exp_bn[i]));
    end
    ch0_req = 1'b0; ch1_req = 1'b0;
    wait_idle(ok);
    check("rr_idle", 32'(ok), 32'd1);

    // tx_done withheld
    next_cycle();
    ch0_req = 1'b1; ch0_byte_num = 16'd64;
    wait_start(ok);
    check("wd_start_seen", 32'(ok), 32'd1);
    next_cycle();
    ch0_req = 1'b0;
    k = 1;
`ifdef UDP_TX_ARB_TIMEOUT_EN
    @(negedge clk);
    while (timeout_err !== 1'b1 && k < 200) begin
      next_cycle();
      k++;
      @(negedge clk);
    end
    check("wd_delay", 32'(k - 1), 32'd100);
    check("wd_no_done", 32'({ch0_done, ch1_done}), 32'd0);
    wait_idle(ok);
    check("wd_idle", 32'(ok), 32'd1);
    // tx_done on the very cycle the limit is reached wins
    next_cycle();
    ch0_req = 1'b1;
    wait_start(ok);
    ch0_req = 1'b0;
    repeat (100) @(posedge clk);
    #1 tx_done = 1'b1;
    next_cycle();
    tx_done = 1'b0;
    @(negedge clk);
    check("wd_prio_done", 32'(ch0_done), 32'd1);
    check("wd_prio_no_err", 32'(timeout_err), 32'd0);
    wait_idle(ok);
    check("wd_prio_idle", 32'(ok), 32'd1);
`else
    seen = 0;
    repeat (10000) begin
      @(negedge clk);
      if (busy !== 1'b1 || timeout_err !== 1'b0) seen++;
    end
    check("nowd_busy_held", 32'(seen), 32'd0);
    check("nowd_grant_held", 32'(ch0_grant), 32'd1);
    next_cycle();
    rst_n = 1'b0;
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    check("nowd_reset_recover", 32'(busy), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      next_cycle();
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) begin
        ch0_req = ($urandom_range(0, 2) != 0);
        ch0_byte_num = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 1500));
      end
      if ($urandom_range(0, 3) == 0) begin
        ch1_req = ($urandom_range(0, 2) != 0);
        ch1_byte_num = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom_range(1, 1500));
      end
      ch0_data = $urandom;
      ch1_data = $urandom;
      tx_req = 1'($urandom_range(0, 1));
      tx_done = ($urandom_range(0, 24) == 0);
    end
    next_cycle();
    rst_n = 1'b1; ch0_req = 1'b0; ch1_req = 1'b0; tx_req = 1'b0; tx_done = 1'b0;
    repeat (5) next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
